// File: rtl/multicycle_ctrl_rv32i.sv
// Multi-cycle main control FSM for the RV32I core: fetch/decode/execute/mem/writeback
// sequencing, immediate/ALU selects, enables and the shared memory req/ready handshake.
module multicycle_ctrl_rv32i #(
    parameter logic RESET_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] instr_opcode,
    input  logic [2:0] instr_funct3,
    input  logic       instr_funct7b5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_o
);
    // state     | meaning
    // FETCH     | read instr at PC, PC+4 -> PC     DECODE  | branch target -> ALUOut, dispatch
    // MEMADR    | rs1+imm -> ALUOut                MEMREAD | load access, MEMWB writes rd
    // MEMWRITE  | store access                     EXECR/I | register / immediate ALU op
    // ALUWB     | ALUOut -> rd                     BRANCH  | compare, PC <- ALUOut if taken
    // JAL/JALR  | PC write + link                  JALR_LINK | oldPC+4 -> ALUOut
    // LUI/AUIPC | U-type result                    TRAP    | illegal opcode, stuck until reset
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
        S_LUI = 4'd12, S_AUIPC = 4'd13, S_JALR_LINK = 4'd14, S_TRAP = 4'd15
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    state_t state, next_state;
    logic   illegal_q;
    logic   taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= RESET_ILLEGAL;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) illegal_q <= 1'b1;
        end
    end

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_reg);
        case (f3)
            3'b000:  alu_decode = (is_reg && f7b5) ? 4'd1 : 4'd0;
            3'b001:  alu_decode = 4'd2;
            3'b010:  alu_decode = 4'd3;
            3'b011:  alu_decode = 4'd4;
            3'b100:  alu_decode = 4'd5;
            3'b101:  alu_decode = f7b5 ? 4'd7 : 4'd6;
            3'b110:  alu_decode = 4'd8;
            default: alu_decode = 4'd9;
        endcase
    endfunction

    always_comb begin
        taken = 1'b0;
        case (instr_funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        imm_sel    = 3'b000;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 4'd0;
        result_src = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (instr_opcode)
                    OPC_LOAD:   begin imm_sel = 3'b000; next_state = S_MEMADR; end
                    OPC_STORE:  begin imm_sel = 3'b001; next_state = S_MEMADR; end
                    OPC_OP:     next_state = S_EXECR;
                    OPC_OPIMM:  begin imm_sel = 3'b000; next_state = S_EXECI; end
                    OPC_BRANCH: begin imm_sel = 3'b010; next_state = S_BRANCH; end
                    OPC_JAL:    begin imm_sel = 3'b011; next_state = S_JAL; end
                    OPC_JALR:   begin imm_sel = 3'b000; next_state = S_JALR; end
                    OPC_LUI:    begin imm_sel = 3'b100; next_state = S_LUI; end
                    OPC_AUIPC:  begin imm_sel = 3'b100; next_state = S_AUIPC; end
                    OPC_MISC:   next_state = S_FETCH;
                    default:    next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_sel    = (instr_opcode == OPC_STORE) ? 3'b001 : 3'b000;
                next_state = (instr_opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = alu_decode(instr_funct3, instr_funct7b5, 1'b1);
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = alu_decode(instr_funct3, instr_funct7b5, 1'b0);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 4'd1;
                pc_write   = taken;
                next_state = (instr_funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                next_state = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                imm_sel    = 3'b100;
                next_state = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                imm_sel    = 3'b100;
                next_state = S_ALUWB;
            end
            default: next_state = S_TRAP;
        endcase
        // Enables must be quiet for the whole reset cycle, including a reset mid-wait.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state_o = state;
endmodule

// File: tb/tb_multicycle_ctrl_rv32i.sv
// Table-driven bench for multicycle_ctrl_rv32i: per-cycle input/expected-output vectors
// plus hand-written trap and reset-mid-wait sequences.
module tb_multicycle_ctrl_rv32i;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] instr_opcode;
    logic [2:0] instr_funct3;
    logic       instr_funct7b5, alu_zero, alu_lt, alu_ltu, mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op, state_o;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl_rv32i dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .instr_funct3(instr_funct3),
        .instr_funct7b5(instr_funct7b5), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .reg_write(reg_write),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OP = 7'h33, OPIMM = 7'h13;
    localparam logic [6:0] BR = 7'h63, JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;
    localparam logic [6:0] FENCE = 7'h0F, BAD = 7'h7F;

    typedef struct {
        logic       rst;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7, z, lt, ltu, rdy;
        logic [3:0] st;
        logic [6:0] ctrl;   // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal}
        logic [2:0] imm;
        logic [1:0] a, b;
        logic [3:0] op;
        logic [1:0] rs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic z, input logic lt, input logic ltu,
                       input logic rdy, input logic [3:0] st, input logic [6:0] ctrl,
                       input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                       input logic [3:0] op, input logic [1:0] rs);
        vec_t v;
        v.rst = rst; v.opc = opc; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu;
        v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.imm = imm; v.a = a; v.b = b; v.op = op;
        v.rs = rs;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        add(1, opc, f3, f7, 0, 0, 0, 1, 4'd0, 7'b1001100, 3'd0, 2'd0, 2'd2, 4'd0, 2'd2);
    endtask

    // mem_ready held low in DECODE: must be ignored there.
    task automatic add_decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [2:0] imm);
        add(1, opc, f3, f7, 0, 0, 0, 0, 4'd1, 7'b0, imm, 2'd1, 2'd1, 4'd0, 2'd0);
    endtask

    task automatic add_aluwb(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        add(1, opc, f3, f7, 0, 0, 0, 1, 4'd8, 7'b0000010, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic rdy);
        @(negedge clk);
        rst_n = rst; instr_opcode = opc; instr_funct3 = f3; instr_funct7b5 = f7;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = rdy;
        #1;
    endtask

    function automatic logic [23:0] outs();
        return {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal,
                imm_sel, alu_src_a, alu_src_b, alu_op, result_src};
    endfunction

    initial begin
        rst_n = 1'b0; instr_opcode = OPIMM; instr_funct3 = 3'd0; instr_funct7b5 = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b1;

        // reset cycle: FETCH selects visible, enables gated even with mem_ready=1
        add(0, OPIMM, 0, 0, 0, 0, 0, 1, 4'd0, 7'b0, 3'd0, 2'd0, 2'd2, 4'd0, 2'd2);
        // ADDI x1,x0,5: states 0,1,7,8
        add_fetch(OPIMM, 0, 0);
        add(1, OPIMM, 0, 0, 0, 0, 0, 1, 4'd1, 7'b0, 3'd0, 2'd1, 2'd1, 4'd0, 2'd0);
        add(1, OPIMM, 0, 0, 0, 0, 0, 1, 4'd7, 7'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0);
        add_aluwb(OPIMM, 0, 0);
        // LW with 3 wait cycles in MEMREAD
        add_fetch(LOAD, 3'b010, 0);
        add_decode(LOAD, 3'b010, 0, 3'd0);
        add(1, LOAD, 3'b010, 0, 0, 0, 0, 0, 4'd2, 7'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0);
        for (int i = 0; i < 3; i++)
            add(1, LOAD, 3'b010, 0, 0, 0, 0, 0, 4'd3, 7'b1010000, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        add(1, LOAD, 3'b010, 0, 0, 0, 0, 1, 4'd3, 7'b1010000, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        add(1, LOAD, 3'b010, 0, 0, 0, 0, 1, 4'd4, 7'b0000010, 3'd0, 2'd0, 2'd0, 4'd0, 2'd1);
        // BEQ taken, with one fetch wait cycle
        add(1, BR, 0, 0, 0, 0, 0, 0, 4'd0, 7'b1000000, 3'd0, 2'd0, 2'd2, 4'd0, 2'd2);
        add_fetch(BR, 0, 0);
        add_decode(BR, 0, 0, 3'd2);
        add(1, BR, 0, 0, 1, 0, 0, 0, 4'd9, 7'b0000100, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0);
        // BEQ not taken
        add_fetch(BR, 0, 0);
        add_decode(BR, 0, 0, 3'd2);
        add(1, BR, 0, 0, 0, 1, 1, 0, 4'd9, 7'b0, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0);
        // BLTU taken
        add_fetch(BR, 3'b110, 0);
        add_decode(BR, 3'b110, 0, 3'd2);
        add(1, BR, 3'b110, 0, 0, 0, 1, 0, 4'd9, 7'b0000100, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0);
        // BGE with lt=1 not taken
        add_fetch(BR, 3'b101, 0);
        add_decode(BR, 3'b101, 0, 3'd2);
        add(1, BR, 3'b101, 0, 1, 1, 1, 0, 4'd9, 7'b0, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0);
        // SUB (R) -> 1, same bits as OP-IMM -> ADD, SRAI -> 7
        add_fetch(OP, 0, 1);
        add_decode(OP, 0, 1, 3'd0);
        add(1, OP, 0, 1, 0, 0, 0, 1, 4'd6, 7'b0, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0);
        add_aluwb(OP, 0, 1);
        add_fetch(OPIMM, 0, 1);
        add_decode(OPIMM, 0, 1, 3'd0);
        add(1, OPIMM, 0, 1, 0, 0, 0, 1, 4'd7, 7'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0);
        add_aluwb(OPIMM, 0, 1);
        add_fetch(OPIMM, 3'b101, 1);
        add_decode(OPIMM, 3'b101, 1, 3'd0);
        add(1, OPIMM, 3'b101, 1, 0, 0, 0, 1, 4'd7, 7'b0, 3'd0, 2'd2, 2'd1, 4'd7, 2'd0);
        add_aluwb(OPIMM, 3'b101, 1);
        // JAL then JALR
        add_fetch(JAL, 0, 0);
        add_decode(JAL, 0, 0, 3'd3);
        add(1, JAL, 0, 0, 0, 0, 0, 1, 4'd10, 7'b0000100, 3'd0, 2'd1, 2'd2, 4'd0, 2'd0);
        add_aluwb(JAL, 0, 0);
        add_fetch(JALR, 0, 0);
        add_decode(JALR, 0, 0, 3'd0);
        add(1, JALR, 0, 0, 0, 0, 0, 1, 4'd11, 7'b0000100, 3'd0, 2'd2, 2'd1, 4'd0, 2'd2);
        add(1, JALR, 0, 0, 0, 0, 0, 1, 4'd14, 7'b0, 3'd0, 2'd1, 2'd2, 4'd0, 2'd0);
        add_aluwb(JALR, 0, 0);
        // LUI, AUIPC
        add_fetch(LUI, 0, 0);
        add_decode(LUI, 0, 0, 3'd4);
        add(1, LUI, 0, 0, 0, 0, 0, 1, 4'd12, 7'b0, 3'd4, 2'd3, 2'd1, 4'd0, 2'd0);
        add_aluwb(LUI, 0, 0);
        add_fetch(AUIPC, 0, 0);
        add_decode(AUIPC, 0, 0, 3'd4);
        add(1, AUIPC, 0, 0, 0, 0, 0, 1, 4'd13, 7'b0, 3'd4, 2'd1, 2'd1, 4'd0, 2'd0);
        add_aluwb(AUIPC, 0, 0);
        // SW zero-wait: 4 cycles
        add_fetch(STORE, 3'b010, 0);
        add_decode(STORE, 3'b010, 0, 3'd1);
        add(1, STORE, 3'b010, 0, 0, 0, 0, 1, 4'd2, 7'b0, 3'd1, 2'd2, 2'd1, 4'd0, 2'd0);
        add(1, STORE, 3'b010, 0, 0, 0, 0, 1, 4'd5, 7'b1110000, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        // FENCE: 2 cycles
        add_fetch(FENCE, 0, 0);
        add_decode(FENCE, 0, 0, 3'd0);
        // branch funct3=010 -> TRAP without PC write, then reset clears it
        add_fetch(BR, 3'b010, 0);
        add_decode(BR, 3'b010, 0, 3'd2);
        add(1, BR, 3'b010, 0, 1, 1, 1, 1, 4'd9, 7'b0, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0);
        add(1, BR, 3'b010, 0, 0, 0, 0, 1, 4'd15, 7'b0000001, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        add(1, OPIMM, 0, 0, 0, 0, 0, 1, 4'd15, 7'b0000001, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        add(0, OPIMM, 0, 0, 0, 0, 0, 1, 4'd15, 7'b0000001, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        add_fetch(OPIMM, 0, 0);
        add(1, OPIMM, 0, 0, 0, 0, 0, 1, 4'd1, 7'b0, 3'd0, 2'd1, 2'd1, 4'd0, 2'd0);
        add(1, OPIMM, 0, 0, 0, 0, 0, 1, 4'd7, 7'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0);
        add_aluwb(OPIMM, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst; instr_opcode = vecs[i].opc; instr_funct3 = vecs[i].f3;
            instr_funct7b5 = vecs[i].f7; alu_zero = vecs[i].z; alu_lt = vecs[i].lt;
            alu_ltu = vecs[i].ltu; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
            chk($sformatf("vec%0d outputs", i), 32'(outs()),
                32'({vecs[i].ctrl, vecs[i].imm, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rs}));
        end

        // illegal opcode 0x7F: sticky TRAP over 10 cycles, one reset cycle clears it
        drive(1, BAD, 0, 0, 1);
        chk("bad fetch state", 32'(state_o), 32'd0);
        drive(1, BAD, 0, 0, 1);
        chk("bad decode illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1, BAD, 0, 0, 1);
            chk($sformatf("trap state c%0d", i), 32'(state_o), 32'd15);
            chk($sformatf("trap illegal/enables c%0d", i),
                32'({illegal, mem_req, ir_write, pc_write, reg_write}), 32'b10000);
        end
        drive(0, OPIMM, 0, 0, 1);
        drive(1, OPIMM, 0, 0, 0);
        chk("post-reset state", 32'(state_o), 32'd0);
        chk("post-reset illegal/mem_req", 32'({illegal, mem_req, ir_write}), 32'b010);

        // reset while LW waits in MEMREAD: request drops, no writes
        drive(1, LOAD, 3'b010, 0, 1);
        drive(1, LOAD, 3'b010, 0, 0);
        drive(1, LOAD, 3'b010, 0, 0);
        drive(1, LOAD, 3'b010, 0, 0);
        chk("wait memread req", 32'({state_o, mem_req, adr_src}), 32'({4'd3, 2'b11}));
        drive(0, LOAD, 3'b010, 0, 1);
        chk("reset mid-wait enables",
            32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 32'd0);
        drive(1, LOAD, 3'b010, 0, 0);
        chk("reset mid-wait state", 32'({state_o, mem_req, reg_write}), 32'({4'd0, 2'b10}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
